// File: rtl/adc_pkg.sv
// adc_pkg: shared types and defaults for the ADC scan sequencer.
package adc_pkg;
    localparam int NUM_CH_D  = 8;
    localparam int CH_W_D    = 3;
    localparam int TIMEOUT_D = 1024;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_TRIG,
        S_WAIT,
        S_STORE,
        S_DONE,
        S_INTERVAL
    } adc_state_e;
endpackage

// File: rtl/adc_chan_picker.sv
// adc_chan_picker: lowest enabled channel, either overall (first=1)
// or strictly above the current index (first=0).
module adc_chan_picker
    import adc_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_D,
    parameter int CH_W   = CH_W_D
) (
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   cur,
    input  logic              first,
    output logic [CH_W-1:0]   nxt,
    output logic              found
);
    // Downward sweep so the last hit is the lowest qualifying channel.
    always_comb begin
        found = 1'b0;
        nxt   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (first || i > int'(cur))) begin
                found = 1'b1;
                nxt   = CH_W'(i);
            end
        end
    end
endmodule

// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: walks the latched channel mask, settles the AMUX,
// triggers the ADC, waits for done with timeout, stores per-channel results.
module adc_scan_sequencer
    import adc_pkg::*;
#(
    parameter int NUM_CH         = NUM_CH_D,
    parameter int CH_W           = CH_W_D,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = TIMEOUT_D
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  start,
    input  logic                  continuous,
    input  logic                  abort,
    input  logic [NUM_CH-1:0]     chan_mask,
    input  logic [15:0]           settle_cycles,
    input  logic [23:0]           interval,
    input  logic                  irq_clr,
    output logic [CH_W-1:0]       adc_amux_sel,
    output logic                  adc_trigger,
    input  logic                  adc_done,
    input  logic [DATA_WIDTH-1:0] adc_data,
    input  logic [CH_W-1:0]       rd_chan,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  res_valid,
    output logic [CH_W-1:0]       res_chan,
    output logic                  busy,
    output logic                  scan_irq,
    output logic                  timeout_err,
    output logic [CH_W-1:0]       err_chan
);
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    adc_state_e            state;
    logic [NUM_CH-1:0]     scan_mask;
    logic [CH_W-1:0]       ch;
    logic [23:0]           cnt;
    logic [TW-1:0]         tcnt;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] bank [NUM_CH];

    logic [CH_W-1:0] first_ch;
    logic [CH_W-1:0] next_ch;
    logic            first_ok;
    logic            next_ok;

    adc_chan_picker #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_first (
        .mask  (chan_mask),
        .cur   ('0),
        .first (1'b1),
        .nxt   (first_ch),
        .found (first_ok)
    );

    adc_chan_picker #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_next (
        .mask  (scan_mask),
        .cur   (ch),
        .first (1'b0),
        .nxt   (next_ch),
        .found (next_ok)
    );

    assign busy    = (state != S_IDLE);
    assign rd_data = (int'(rd_chan) < NUM_CH) ? bank[rd_chan] : '0;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state        <= S_IDLE;
            scan_mask    <= '0;
            ch           <= '0;
            cnt          <= '0;
            tcnt         <= '0;
            data_q       <= '0;
            adc_amux_sel <= '0;
            adc_trigger  <= 1'b0;
            res_valid    <= 1'b0;
            res_chan     <= '0;
            scan_irq     <= 1'b0;
            timeout_err  <= 1'b0;
            err_chan     <= '0;
        end else begin
            adc_trigger <= 1'b0;
            res_valid   <= 1'b0;
            // Clear first so a same-cycle set below overrides it.
            if (irq_clr) begin
                scan_irq    <= 1'b0;
                timeout_err <= 1'b0;
            end
            if (abort) begin
                state <= S_IDLE;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start && first_ok) begin
                            scan_mask    <= chan_mask;
                            ch           <= first_ch;
                            adc_amux_sel <= first_ch;
                            cnt          <= 24'(settle_cycles);
                            state        <= S_SETTLE;
                        end
                    end
                    S_SETTLE: begin
                        if (cnt == 24'd0) begin
                            adc_trigger <= 1'b1;
                            state       <= S_TRIG;
                        end else begin
                            cnt <= cnt - 24'd1;
                        end
                    end
                    S_TRIG: begin
                        tcnt  <= '0;
                        state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (adc_done) begin
                            data_q    <= adc_data;
                            res_valid <= 1'b1;
                            res_chan  <= ch;
                            state     <= S_STORE;
                        end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                            data_q      <= '0;
                            timeout_err <= 1'b1;
                            err_chan    <= ch;
                            res_valid   <= 1'b1;
                            res_chan    <= ch;
                            state       <= S_STORE;
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end
                    S_STORE: begin
                        if (next_ok) begin
                            ch           <= next_ch;
                            adc_amux_sel <= next_ch;
                            cnt          <= 24'(settle_cycles);
                            state        <= S_SETTLE;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        scan_irq <= 1'b1;
                        if (continuous && interval != 24'd0) begin
                            cnt   <= interval;
                            state <= S_INTERVAL;
                        end else if (continuous && first_ok) begin
                            scan_mask    <= chan_mask;
                            ch           <= first_ch;
                            adc_amux_sel <= first_ch;
                            cnt          <= 24'(settle_cycles);
                            state        <= S_SETTLE;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_INTERVAL: begin
                        if (!continuous) begin
                            state <= S_IDLE;
                        end else if (cnt == 24'd1) begin
                            if (first_ok) begin
                                scan_mask    <= chan_mask;
                                ch           <= first_ch;
                                adc_amux_sel <= first_ch;
                                cnt          <= 24'(settle_cycles);
                                state        <= S_SETTLE;
                            end else begin
                                state <= S_IDLE;
                            end
                        end else begin
                            cnt <= cnt - 24'd1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < NUM_CH; i++) bank[i] <= '0;
        end else if (state == S_STORE && !abort) begin
            bank[ch] <= data_q;
        end
    end
endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb_adc_scan_sequencer: directed checks of scan order, timing,
// timeout, continuous mode, abort and reset behaviour.
module tb_adc_scan_sequencer;
    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  chan_mask = '0;
    logic [15:0] settle_cycles = 16'd3;
    logic [23:0] interval = '0;
    logic        irq_clr = 1'b0;
    logic [2:0]  adc_amux_sel;
    logic        adc_trigger;
    logic        adc_done = 1'b0;
    logic [31:0] adc_data = '0;
    logic [2:0]  rd_chan = '0;
    logic [31:0] rd_data;
    logic        res_valid;
    logic [2:0]  res_chan;
    logic        busy;
    logic        scan_irq;
    logic        timeout_err;
    logic [2:0]  err_chan;

    int checks = 0;
    int failures = 0;

    adc_scan_sequencer dut (
        .PCLK          (PCLK),
        .PRESETn       (PRESETn),
        .start         (start),
        .continuous    (continuous),
        .abort         (abort),
        .chan_mask     (chan_mask),
        .settle_cycles (settle_cycles),
        .interval      (interval),
        .irq_clr       (irq_clr),
        .adc_amux_sel  (adc_amux_sel),
        .adc_trigger   (adc_trigger),
        .adc_done      (adc_done),
        .adc_data      (adc_data),
        .rd_chan       (rd_chan),
        .rd_data       (rd_data),
        .res_valid     (res_valid),
        .res_chan      (res_chan),
        .busy          (busy),
        .scan_irq      (scan_irq),
        .timeout_err   (timeout_err),
        .err_chan      (err_chan)
    );

    always #5 PCLK = ~PCLK;

    // ADC model: done and 0x100+ch two cycles after the trigger cycle.
    logic no_done = 1'b0;
    logic d1 = 1'b0;
    always @(posedge PCLK) begin
        d1       <= adc_trigger && !no_done;
        adc_done <= d1;
        adc_data <= d1 ? (32'h100 + 32'(adc_amux_sel)) : 32'h0;
    end

    int cyc = 0;
    int trig_n = 0;
    int trig_cyc [64];
    int rv_n = 0;
    int rv_cyc [64];
    logic [2:0] rv_ch [64];
    always @(posedge PCLK) begin
        cyc = cyc + 1;
        if (adc_trigger && trig_n < 64) begin
            trig_cyc[trig_n] = cyc;
            trig_n = trig_n + 1;
        end
        if (res_valid && rv_n < 64) begin
            rv_cyc[rv_n] = cyc;
            rv_ch[rv_n] = res_chan;
            rv_n = rv_n + 1;
        end
    end

    task automatic tick();
        @(negedge PCLK);
    endtask

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic rd(input logic [2:0] c, input logic [31:0] exp,
                      input string tag);
        rd_chan = c;
        #1;
        check(tag, rd_data, exp);
    endtask

    task automatic pulse_start(input logic [7:0] m);
        chan_mask = m;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int max, input string tag);
        int n = 0;
        tick();
        while (busy && n < max) begin
            tick();
            n++;
        end
        check(tag, 32'(busy), 32'h0);
    endtask

    task automatic clear_irq();
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
    endtask

    int tb, rb, sc, n, seen;

    initial begin
        repeat (3) tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_trig", 32'(adc_trigger), 0);
        check("rst_rv", 32'(res_valid), 0);
        check("rst_irq", 32'(scan_irq), 0);
        check("rst_terr", 32'(timeout_err), 0);
        check("rst_amux", 32'(adc_amux_sel), 0);
        rd(3'd0, 32'h0, "rst_bank0");
        PRESETn = 1'b1;
        tick();

        // Single shot over channels 0 and 2.
        tb = trig_n; rb = rv_n;
        sc = cyc + 1;
        pulse_start(8'h05);
        wait_idle(200, "ss_idle");
        check("ss_rvcnt", 32'(rv_n - rb), 2);
        check("ss_ch0", 32'(rv_ch[rb]), 0);
        check("ss_ch2", 32'(rv_ch[rb+1]), 2);
        check("ss_trigcnt", 32'(trig_n - tb), 2);
        check("ss_settle", 32'(trig_cyc[tb] - sc), 5);
        check("ss_latency", 32'(rv_cyc[rb] - sc), 8);
        rd(3'd0, 32'h100, "ss_res0");
        rd(3'd2, 32'h102, "ss_res2");
        rd(3'd1, 32'h0, "ss_res1");
        check("ss_irq", 32'(scan_irq), 1);
        check("ss_amux", 32'(adc_amux_sel), 2);
        clear_irq();
        check("clr_irq", 32'(scan_irq), 0);

        // Timeout on channel 1.
        no_done = 1'b1;
        pulse_start(8'h02);
        wait_idle(2000, "to_idle");
        no_done = 1'b0;
        check("to_err", 32'(timeout_err), 1);
        check("to_chan", 32'(err_chan), 1);
        check("to_irq", 32'(scan_irq), 1);
        rd(3'd1, 32'h0, "to_res1");
        clear_irq();
        check("to_clr", 32'(timeout_err), 0);

        // Mask change and start while busy; irq_clr during DONE.
        rb = rv_n; tb = trig_n;
        pulse_start(8'h05);
        tick();
        chan_mask = 8'hFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(res_valid && res_chan == 3'd2) && n < 100) begin
            tick();
            n++;
        end
        check("mm_store2", 32'(res_valid), 1);
        tick();
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        check("mm_irqwin", 32'(scan_irq), 1);
        wait_idle(50, "mm_idle");
        check("mm_rvcnt", 32'(rv_n - rb), 2);
        check("mm_trigcnt", 32'(trig_n - tb), 2);
        clear_irq();

        // Continuous with interval 10 on channel 7.
        tb = trig_n;
        interval = 24'd10;
        continuous = 1'b1;
        pulse_start(8'h80);
        seen = 0; n = 0;
        while (seen < 2 && n < 200) begin
            if (res_valid) seen++;
            if (seen < 2) tick();
            n++;
        end
        check("ct_seen", 32'(seen), 2);
        check("ct_period", 32'(trig_cyc[tb+1] - trig_cyc[tb]), 19);
        tick();
        tick();
        continuous = 1'b0;
        tick();
        check("ct_stop", 32'(busy), 0);
        repeat (40) tick();
        check("ct_notrig", 32'(trig_n - tb), 2);
        check("ct_irq", 32'(scan_irq), 1);
        clear_irq();
        interval = '0;

        // Abort during WAIT on channel 3.
        rb = rv_n;
        pulse_start(8'h18);
        n = 0;
        while (!adc_trigger && n < 50) begin
            tick();
            n++;
        end
        check("ab_amux", 32'(adc_amux_sel), 3);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_busy", 32'(busy), 0);
        repeat (10) tick();
        check("ab_rv", 32'(rv_n - rb), 0);
        check("ab_irq", 32'(scan_irq), 0);
        rd(3'd3, 32'h0, "ab_res3");
        rd(3'd0, 32'h100, "ab_res0");

        // Empty mask start is ignored.
        pulse_start(8'h00);
        check("zm_busy0", 32'(busy), 0);
        tick();
        check("zm_busy1", 32'(busy), 0);

        // Asynchronous reset mid-SETTLE, then a normal scan.
        pulse_start(8'h04);
        tick();
        check("rs_busy", 32'(busy), 1);
        check("rs_amux", 32'(adc_amux_sel), 2);
        #2 PRESETn = 1'b0;
        #1;
        check("rs_busy0", 32'(busy), 0);
        check("rs_amux0", 32'(adc_amux_sel), 0);
        rd(3'd0, 32'h0, "rs_bank0");
        tick();
        PRESETn = 1'b1;
        tick();
        rb = rv_n;
        pulse_start(8'h04);
        wait_idle(200, "rs_idle");
        check("rs_rv", 32'(rv_n - rb), 1);
        rd(3'd2, 32'h102, "rs_res2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
